// File: rtl/ahblite_pkg.sv
// Shared AHB-Lite encodings, SRAM slave FSM state and lane helpers.
// Used by ahblite_sram_slave (optional macro AHBLITE_SRAM_ALIGN_ERR_EN).
package ahblite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // Oversized HSIZE falls through to a full-word mask.
  function automatic logic [3:0] lane_mask(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic [3:0] m;
    unique case (1'b1)
      (size == HSIZE_BYTE): m = 4'b0001 << a;
      (size == HSIZE_HALF): m = a[1] ? 4'b1100 : 4'b0011;
      default:              m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic size_err(
    input logic [2:0] size,
    input logic [1:0] a
  );
    return (size == HSIZE_HALF && a[0])
        || (size == HSIZE_WORD && a != 2'b00)
        || (size > HSIZE_WORD);
  endfunction

endpackage

// File: rtl/ahblite_sram_bytemem.sv
// Four byte-lane SRAM with per-lane write enables and registered read.
// Read-first on address collision; the slave merges fresh lanes itself.
module ahblite_sram_bytemem #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ahblite_sram_slave.sv
// AHB-Lite SRAM slave: wait states, byte lanes, RAW forwarding.
// Define AHBLITE_SRAM_ALIGN_ERR_EN for misalignment/size ERROR replies.
module ahblite_sram_slave
  import ahblite_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam logic [2:0] WS = 3'(WAIT_STATES);

  state_t                state;
  logic [2:0]            wcnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            mask_q;
  logic                  write_q;
  logic [3:0]            fwd_mask;
  logic [31:0]           fwd_data;
  logic                  zero_q;
  logic [31:0]           mem_rdata;

  logic [ADDR_WIDTH-1:0] addr_w;
  logic                  slot_free;
  logic                  accept;
  logic                  err;
  logic                  commit;
  logic                  rd_go;
  logic                  unused_ok;

  assign addr_w = HADDR[ADDR_WIDTH+1:2];
  assign unused_ok = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

  assign slot_free = (state == ST_IDLE)
                  || (state == ST_ERR2)
                  || (state == ST_DATA && HREADYOUT);
  assign accept = HSEL & HREADY & HTRANS[1] & slot_free;

`ifdef AHBLITE_SRAM_ALIGN_ERR_EN
  assign err = size_err(HSIZE, HADDR[1:0]);
`else
  assign err = 1'b0;
`endif

  assign commit = (state == ST_DATA) && HREADYOUT
               && write_q && !HRESET;
  assign rd_go  = accept && !HWRITE && !err && !HRESET;

  ahblite_sram_bytemem #(.AW(ADDR_WIDTH)) u_mem (
    .clk   (HCLK),
    .we    (commit ? mask_q : 4'b0000),
    .waddr (addr_q),
    .wdata (HWDATA),
    .re    (rd_go),
    .raddr (addr_w),
    .rdata (mem_rdata)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= HRESP_OKAY;
      wcnt      <= '0;
      addr_q    <= '0;
      mask_q    <= '0;
      write_q   <= 1'b0;
      fwd_mask  <= '0;
      zero_q    <= 1'b1;
    end else begin
      // A write retiring into the word being read wins lane by lane.
      if (rd_go) begin
        fwd_mask <= (commit && addr_q == addr_w) ? mask_q : 4'b0000;
        fwd_data <= HWDATA;
        zero_q   <= 1'b0;
      end
      unique case (1'b1)
        (state == ST_ERR1): begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= HRESP_ERROR;
        end
        (state == ST_DATA && !HREADYOUT): begin
          wcnt      <= wcnt - 3'd1;
          HREADYOUT <= (wcnt == 3'd1);
        end
        default: begin
          if (accept && err) begin
            state     <= ST_ERR1;
            HREADYOUT <= 1'b0;
            HRESP     <= HRESP_ERROR;
            write_q   <= 1'b0;
            if (!HWRITE) zero_q <= 1'b1;
          end else if (accept) begin
            state     <= ST_DATA;
            HREADYOUT <= (WS == 3'd0);
            HRESP     <= HRESP_OKAY;
            wcnt      <= WS;
            addr_q    <= addr_w;
            mask_q    <= lane_mask(HSIZE, HADDR[1:0]);
            write_q   <= HWRITE;
          end else begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            write_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    HRDATA = '0;
    if (!zero_q) begin
      for (int i = 0; i < 4; i++) begin
        HRDATA[8*i +: 8] = fwd_mask[i] ? fwd_data[8*i +: 8]
                                       : mem_rdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ahblite_sram_slave.sv
// Bench for ahblite_sram_slave: WAIT_STATES=0 and =3 instances, vector
// table, hand sequences and a random run against a byte-array model.
module tb_ahblite_sram_slave;
  import ahblite_pkg::*;

`ifdef AHBLITE_SRAM_ALIGN_ERR_EN
  localparam bit AE = 1'b1;
`else
  localparam bit AE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       sel, wr, ho;
  logic [1:0][31:0] addr, wdata, rdata;
  logic [1:0][1:0]  trans, resp;
  logic [1:0][2:0]  size;

  ahblite_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[0]), .HADDR(addr[0]),
    .HTRANS(trans[0]), .HSIZE(size[0]), .HWRITE(wr[0]),
    .HWDATA(wdata[0]), .HREADY(ho[0]), .HREADYOUT(ho[0]),
    .HRESP(resp[0]), .HRDATA(rdata[0])
  );

  ahblite_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u3 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel[1]), .HADDR(addr[1]),
    .HTRANS(trans[1]), .HSIZE(size[1]), .HWRITE(wr[1]),
    .HWDATA(wdata[1]), .HREADY(ho[1]), .HREADYOUT(ho[1]),
    .HRESP(resp[1]), .HRDATA(rdata[1])
  );

  int npass = 0;
  int ntotal = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic bus_idle(input int d);
    sel[d] = 1'b0; trans[d] = HTRANS_IDLE; wr[d] = 1'b0;
    size[d] = HSIZE_WORD; addr[d] = '0;
  endtask

  // One isolated transfer; samples every data-phase cycle at negedge.
  task automatic xfer(input int d, input logic w, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic [1:0] r0,
                      output logic [1:0] r1, output int lows,
                      output logic stable, output logic tmo);
    logic [31:0] first;
    @(negedge clk);
    sel[d] = 1'b1; trans[d] = HTRANS_NONSEQ; addr[d] = a;
    size[d] = sz; wr[d] = w;
    @(posedge clk);
    @(negedge clk);
    bus_idle(d);
    wdata[d] = wd;
    lows = 0; stable = 1'b1; tmo = 1'b0;
    r0 = resp[d]; first = rdata[d];
    while (!ho[d]) begin
      lows++;
      if (lows > 20) begin tmo = 1'b1; break; end
      @(negedge clk);
      if (rdata[d] !== first) stable = 1'b0;
    end
    rd = rdata[d]; r1 = resp[d];
  endtask

  logic [7:0] m [2][4096];
  int ws [2] = '{0, 3};

  task automatic model(input int d, input logic w, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] erd, output logic [1:0] eresp,
                       output int elows);
    int n, ba, wb, lane;
    if (AE && (sz > 3'd2 || (sz == 3'd1 && a[0])
        || (sz == 3'd2 && a[1:0] != 2'b00))) begin
      erd = '0; eresp = 2'b01; elows = 1;
    end else begin
      n  = (sz == 3'd0) ? 1 : (sz == 3'd1) ? 2 : 4;
      ba = int'(a[11:0]) / n * n;
      if (w) begin
        for (int k = 0; k < n; k++) begin
          lane = (ba + k) % 4;
          m[d][ba+k] = wd[8*lane +: 8];
        end
      end
      wb  = int'(a[11:0]) / 4 * 4;
      erd = {m[d][wb+3], m[d][wb+2], m[d][wb+1], m[d][wb]};
      eresp = 2'b00; elows = ws[d];
    end
  endtask

  logic [31:0] rd, erd;
  logic [1:0]  r0, r1, eresp;
  int          lows, elows;
  logic        stable, tmo;

  task automatic zero_region(input int d);
    for (int i = 0; i < 16; i++) begin
      xfer(d, 1'b1, HSIZE_WORD, 32'(i*4), 32'h0, rd, r0, r1, lows,
           stable, tmo);
      chk("zero_tmo", 32'(tmo), 32'd0);
    end
    for (int i = 0; i < 64; i++) m[d][i] = 8'h00;
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic [1:0]  eresp;
    int          elows;
  } vec_t;

  vec_t tv [12];

  initial begin
    tv[0]  = '{1'b1, HSIZE_WORD, 32'h20, 32'h0, 32'h0, 2'd0, 0};
    tv[1]  = '{1'b1, HSIZE_BYTE, 32'h21, 32'h0000AA00, 32'h0, 2'd0, 0};
    tv[2]  = '{1'b1, HSIZE_HALF, 32'h22, 32'h55660000, 32'h0, 2'd0, 0};
    tv[3]  = '{1'b0, HSIZE_WORD, 32'h20, 32'h0, 32'h5566AA00, 2'd0, 0};
    tv[4]  = '{1'b0, HSIZE_BYTE, 32'h21, 32'h0, 32'h5566AA00, 2'd0, 0};
    tv[5]  = '{1'b1, HSIZE_WORD, 32'h00, 32'h11223344, 32'h0, 2'd0, 0};
    tv[6]  = '{1'b1, HSIZE_WORD, 32'h02, 32'hCAFEF00D, 32'h0,
               AE ? 2'd1 : 2'd0, AE ? 1 : 0};
    tv[7]  = '{1'b0, HSIZE_WORD, 32'h00, 32'h0,
               AE ? 32'h11223344 : 32'hCAFEF00D, 2'd0, 0};
    tv[8]  = '{1'b0, HSIZE_HALF, 32'h03, 32'h0,
               AE ? 32'h0 : 32'hCAFEF00D, AE ? 2'd1 : 2'd0, AE ? 1 : 0};
    tv[9]  = '{1'b1, 3'd3, 32'h04, 32'h99887766, 32'h0,
               AE ? 2'd1 : 2'd0, AE ? 1 : 0};
    tv[10] = '{1'b0, HSIZE_WORD, 32'h04, 32'h0,
               AE ? 32'h0 : 32'h99887766, 2'd0, 0};
    tv[11] = '{1'b0, HSIZE_WORD, 32'h1020, 32'h0, 32'h5566AA00, 2'd0, 0};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin bus_idle(d); wdata[d] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("rst_ho%0d", d), 32'(ho[d]), 32'd1);
        chk($sformatf("rst_resp%0d", d), 32'(resp[d]), 32'd0);
        chk($sformatf("rst_rdata%0d", d), rdata[d], 32'd0);
      end
      @(negedge clk);
    end

    zero_region(0);
    zero_region(1);

    for (int i = 0; i < 12; i++) begin
      xfer(0, tv[i].w, tv[i].sz, tv[i].a, tv[i].wd, rd, r0, r1, lows,
           stable, tmo);
      chk($sformatf("tv%0d_tmo", i), 32'(tmo), 32'd0);
      chk($sformatf("tv%0d_resp0", i), 32'(r0), 32'(tv[i].eresp));
      chk($sformatf("tv%0d_resp1", i), 32'(r1), 32'(tv[i].eresp));
      chk($sformatf("tv%0d_lows", i), 32'(lows), 32'(tv[i].elows));
      if (!tv[i].w) chk($sformatf("tv%0d_rd", i), rd, tv[i].erd);
    end

    // Back-to-back write then read of the same word.
    @(negedge clk);
    sel[0] = 1'b1; trans[0] = HTRANS_NONSEQ; addr[0] = 32'h10;
    size[0] = HSIZE_WORD; wr[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_w_ho", 32'(ho[0]), 32'd1);
    chk("b2b_w_resp", 32'(resp[0]), 32'd0);
    wr[0] = 1'b0; wdata[0] = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    chk("b2b_r_ho", 32'(ho[0]), 32'd1);
    chk("b2b_r_resp", 32'(resp[0]), 32'd0);
    chk("b2b_r_data", rdata[0], 32'hDEADBEEF);
    bus_idle(0);
    xfer(0, 1'b0, HSIZE_WORD, 32'h10, 32'h0, rd, r0, r1, lows, stable,
         tmo);
    chk("b2b_mem", rd, 32'hDEADBEEF);

    // BUSY and unselected NONSEQ must not be accepted.
    @(negedge clk);
    sel[0] = 1'b1; trans[0] = HTRANS_BUSY; addr[0] = 32'h18;
    size[0] = HSIZE_WORD; wr[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("busy_ho", 32'(ho[0]), 32'd1);
    chk("busy_resp", 32'(resp[0]), 32'd0);
    wdata[0] = 32'hFFFFFFFF; sel[0] = 1'b0; trans[0] = HTRANS_NONSEQ;
    @(posedge clk);
    @(negedge clk);
    chk("nosel_ho", 32'(ho[0]), 32'd1);
    chk("nosel_resp", 32'(resp[0]), 32'd0);
    bus_idle(0);
    @(posedge clk);
    xfer(0, 1'b0, HSIZE_WORD, 32'h18, 32'h0, rd, r0, r1, lows, stable,
         tmo);
    chk("busy_mem", rd, 32'h0);

    // Three wait states on a read.
    xfer(1, 1'b1, HSIZE_WORD, 32'h08, 32'h0BADCAFE, rd, r0, r1, lows,
         stable, tmo);
    chk("ws3_w_lows", 32'(lows), 32'd3);
    xfer(1, 1'b0, HSIZE_WORD, 32'h08, 32'h0, rd, r0, r1, lows, stable,
         tmo);
    chk("ws3_r_lows", 32'(lows), 32'd3);
    chk("ws3_r_stable", 32'(stable), 32'd1);
    chk("ws3_r_data", rd, 32'h0BADCAFE);
    chk("ws3_r_resp", 32'(r1), 32'd0);

    // Reset during the second wait cycle drops the write.
    xfer(1, 1'b1, HSIZE_WORD, 32'h30, 32'h55555555, rd, r0, r1, lows,
         stable, tmo);
    @(negedge clk);
    sel[1] = 1'b1; trans[1] = HTRANS_NONSEQ; addr[1] = 32'h30;
    size[1] = HSIZE_WORD; wr[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus_idle(1);
    wdata[1] = 32'hAAAAAAAA;
    chk("rstw_c1_ho", 32'(ho[1]), 32'd0);
    @(negedge clk);
    chk("rstw_c2_ho", 32'(ho[1]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_ho", 32'(ho[1]), 32'd1);
    chk("rstw_resp", 32'(resp[1]), 32'd0);
    chk("rstw_rdata", rdata[1], 32'd0);
    xfer(1, 1'b0, HSIZE_WORD, 32'h30, 32'h0, rd, r0, r1, lows, stable,
         tmo);
    chk("rstw_mem", rd, 32'h55555555);
    chk("rstw_tmo", 32'(tmo), 32'd0);

    zero_region(0);
    zero_region(1);
    for (int it = 0; it < 60; it++) begin
      int d, szr;
      logic w;
      logic [2:0] sz;
      logic [31:0] a, wd;
      d   = int'($urandom_range(0, 1));
      w   = 1'($urandom_range(0, 1));
      szr = int'($urandom_range(0, 3));
      sz  = (szr == 3) ? 3'($urandom_range(3, 7)) : 3'(szr);
      a   = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
      wd  = $urandom;
      model(d, w, sz, a, wd, erd, eresp, elows);
      xfer(d, w, sz, a, wd, rd, r0, r1, lows, stable, tmo);
      chk($sformatf("rnd%0d_tmo", it), 32'(tmo), 32'd0);
      chk($sformatf("rnd%0d_resp0", it), 32'(r0), 32'(eresp));
      chk($sformatf("rnd%0d_resp1", it), 32'(r1), 32'(eresp));
      chk($sformatf("rnd%0d_lows", it), 32'(lows), 32'(elows));
      if (!w) begin
        chk($sformatf("rnd%0d_rd", it), rd, erd);
        chk($sformatf("rnd%0d_stable", it), 32'(stable), 32'd1);
      end
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
